// File: rtl/data_inf_c_intc_s2m_lazy_fifo_pkg.sv
// Shared helpers for the lazy S2M FIFO router: storage/pointer widths and
// the per-beat target-set decode.
package data_inf_c_lazy_pkg;

    localparam int MAX_NUM     = 32;
    localparam int LAZY_FIFO_W = 1 + 8;
    localparam int LAZY_PTR_W  = $clog2(4) + 1;

    function automatic int lazy_fifo_w(input int lazise, input int dsize);
        return lazise + dsize;
    endfunction

    // One extra bit beyond the index tells full from empty.
    function automatic int lazy_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Empty result means the beat has no destination and must be dropped.
    function automatic logic [MAX_NUM-1:0] decode_targets(
        input logic               bcast_en,
        input logic [MAX_NUM-1:0] mask,
        input logic [MAX_NUM-1:0] addr,
        input int                 num
    );
        logic [MAX_NUM-1:0] keep;
        logic [MAX_NUM-1:0] tgt;
        keep = '1;
        if (num < MAX_NUM) keep = ~({MAX_NUM{1'b1}} << num);
        tgt = '0;
        if (bcast_en)
            tgt = mask & keep;
        else if (addr < $unsigned(num))
            tgt[addr[4:0]] = 1'b1;
        return tgt;
    endfunction

endpackage

// File: rtl/data_inf_c.sv
// Valid/ready stream interface carrying DSIZE-bit data.
interface data_inf_c #(
    parameter int DSIZE = 8
);
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (output valid, output data, input ready);
    modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_inf_c_intc_s2m_lazy_fifo_chn.sv
// Single-channel synchronous FIFO holding {lazy, data} words; pointers wrap
// modulo 2*DEPTH so full and empty are distinguished by the top pointer bit.
module lazy_chn_fifo
    import data_inf_c_lazy_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int PW = lazy_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    // A full FIFO refuses the write even when it is popped the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/data_inf_c_intc_s2m_lazy_fifo.sv
// One-slaver to NUM-master stream router with a lazy sideband, per-master
// elastic FIFOs, multicast, and a saturating count of dropped beats.
module data_inf_c_intc_s2m_lazy_fifo
    import data_inf_c_lazy_pkg::*;
#(
    parameter int NUM    = 8,
    parameter int NSIZE  = $clog2(NUM),
    parameter int DSIZE  = 8,
    parameter int LAZISE = 1,
    parameter int DEPTH  = 4,
    parameter int CNTW   = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [NSIZE-1:0]  addr,
    input  logic              bcast_en,
    input  logic [NUM-1:0]    bcast_mask,
    input  logic [LAZISE-1:0] s00_lazy_data,
    data_inf_c.slaver         s00,
    data_inf_c.master         m00 [NUM-1:0],
    output logic [LAZISE-1:0] m00_lazy_data [NUM-1:0],
    output logic [NUM-1:0]    fifo_full,
    output logic [CNTW-1:0]   drop_cnt
);
    localparam int FW = lazy_fifo_w(LAZISE, DSIZE);

    logic [MAX_NUM-1:0] mask_ext;
    logic [MAX_NUM-1:0] addr_ext;
    logic [MAX_NUM-1:0] tgt_all;
    logic [NUM-1:0]     targets;
    logic [NUM-1:0]     push;
    logic               accept;
    logic               drop;
    logic [FW-1:0]      din;

    always_comb begin
        mask_ext = '0;
        mask_ext[NUM-1:0] = bcast_mask;
        addr_ext = '0;
        addr_ext[NSIZE-1:0] = addr;
    end

    assign tgt_all = decode_targets(bcast_en, mask_ext, addr_ext, NUM);
    assign targets = tgt_all[NUM-1:0];

    // Ready looks only at registered FIFO state, never at m00[*].ready.
    assign s00.ready = &(~targets | ~fifo_full);
    assign accept    = s00.valid & s00.ready;
    assign push      = {NUM{accept}} & targets;
    assign drop      = accept & ~(|tgt_all);
    assign din       = {s00_lazy_data, s00.data};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop && (drop_cnt != {CNTW{1'b1}}))
            drop_cnt <= drop_cnt + 1'b1;
    end

    for (genvar k = 0; k < NUM; k++) begin : g_chn
        logic [FW-1:0] dout;
        logic          empty;

        lazy_chn_fifo #(
            .WIDTH (FW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock (clock),
            .rst_n (rst_n),
            .push  (push[k]),
            .din   (din),
            .full  (fifo_full[k]),
            .pop   (m00[k].ready),
            .dout  (dout),
            .empty (empty)
        );

        assign m00[k].valid     = ~empty;
        assign m00[k].data      = dout[DSIZE-1:0];
        assign m00_lazy_data[k] = dout[FW-1:DSIZE];
    end

endmodule

// File: doc/data_inf_c_intc_s2m_lazy_fifo.md
Name: data_inf_c_intc_S2M_lazy_fifo

Overview:
Single-slaver to NUM-master router for data_inf_c streams, carrying a lazy sideband word alongside each beat. Successor to the combinational S2M-with-lazy router, with these additions:
- a per-master elastic FIFO of DEPTH entries, so one stalled master does not block traffic to the others;
- a broadcast/multicast mode;
- out-of-range address drop with a drop counter.
Sits between a single producer and NUM consumer pipelines in the stream fabric.

Parameters:
NUM, 8, number of master channels (2..32)
NSIZE, $clog2(NUM), address width
DSIZE, 8, s00/m00 data width
LAZISE, 1, lazy sideband width
DEPTH, 4, per-channel FIFO entries; power of 2, >=2
CNTW, 16, drop counter width

Ports:
clock  input  1  single clock, shared by all interfaces
rst_n  input  1  asynchronous active-low reset
addr  input  NSIZE  destination index, sync to s00.valid (used when bcast_en=0)
bcast_en  input  1  sync to s00.valid; 1 = deliver to every channel set in bcast_mask
bcast_mask  input  NUM  multicast target set, sync to s00.valid
s00_lazy_data  input  LAZISE  sideband, sync to s00.data
s00  slaver  data_inf_c#(DSIZE)  input stream
m00[NUM-1:0]  master  data_inf_c#(DSIZE)  output streams
m00_lazy_data[NUM-1:0]  output  LAZISE  sideband aligned to m00[k].data
fifo_full  output  NUM  per-channel full flag
drop_cnt  output  CNTW  count of discarded beats; saturating

Behaviour:
- Storage: each channel FIFO stores {lazy, data} (LAZISE+DSIZE bits), DEPTH entries, with wrapping pointers plus an extra bit for the full/empty distinction.
- Target set T, decoded from the current beat:
  - bcast_en=1: T = bcast_mask.
  - bcast_en=0 and addr<NUM: T = one-hot(addr).
  - bcast_en=0 and addr>=NUM: T = empty (drop case).
- s00.ready is combinational: ready = AND over k in T of !full[k]. It depends only on registered full flags, never on m00[k].ready, so there is no comb path from output ready to input ready.
  - A full channel does not accept a same-cycle write even if it is popped that cycle.
- Write (s00.valid & s00.ready):
  - push {s00_lazy_data, s00.data} into every FIFO in T, in the same cycle;
  - a multicast beat is never partially delivered.
- Drop: if T is empty, ready=1 and the beat is discarded.
  - drop_cnt increments by 1, saturating at all-ones.
  - Covers both bcast_en=1 with mask=0 and an out-of-range addr.
- Latency: a beat written at edge N is visible on m00[k].valid after edge N; first-word latency is 1 cycle.
- Output k: m00[k].valid = !empty[k]. m00[k].data and m00_lazy_data[k] come from the head entry and are stable while valid & !ready. Pop on valid & ready.
- Simultaneous push and pop on a non-full channel: occupancy is unchanged and both pointers advance.
- Throughput: 1 beat/cycle per channel when all its consumers are ready.
- Ordering: per-channel FIFO order equals s00 acceptance order.
- Reset (async assert, sync deassert assumed upstream):
  - all pointers 0 (all FIFOs empty);
  - m00[*].valid=0, fifo_full=0, drop_cnt=0;
  - FIFO RAM contents are don't-care.
  - Reset mid-transfer discards all buffered beats; s00.ready may be 1 during reset only if T is empty or every channel in T has space.
- Wrap: pointers wrap modulo 2*DEPTH. full = (wr^rd)=={1,0...}, empty = wr==rd.
- Unknown or X addr while s00.valid=0 must not affect state.

Decomposition:
- Package data_inf_c_lazy_pkg:
  - function decoding a target vector from (bcast_en, bcast_mask, addr, NUM);
  - localparams for the FIFO width and pointer width ($clog2(DEPTH)+1).
- Sub-module lazy_chn_fifo: a single-channel sync FIFO with ports clock, rst_n, push, din, full, pop, dout, empty. It is instantiated NUM times in a generate loop.
- The top holds the target decode, the ready AND-reduction, the drop counter and the data_inf_c binding.

Test Plan:
- Unicast: addr=3, 4 beats 0x11..0x14 with lazy=1, m00[3].ready=1 → m00[3] emits 0x11..0x14 in order, lazy=1 each, first valid 1 cycle after the first accept; other channels stay valid=0.
- Backpressure isolation: m00[2].ready=0; send 4 beats to ch2, then 1 beat to ch5. With DEPTH=4 → fifo_full[2]=1, the ch5 beat is accepted and delivered, and a 5th ch2 beat sees s00.ready=0.
- Full + pop same cycle: ch2 full, m00[2].ready=1 with a ch2 beat pending → s00.ready=0 that cycle, beat accepted the next cycle; no loss and no duplicate.
- Multicast: bcast_en=1, mask=8'b1000_0101, data 0xA5, ch7 full → s00.ready=0 until ch7 drains, then 0xA5 appears once on ch0, ch2 and ch7 only.
- Drop: NUM=6, addr=7, 3 beats, then bcast_en=1 with mask=0, 1 beat → ready=1 throughout, no m00 valid, drop_cnt=4; drop_cnt saturates at 0xFFFF under long stimulus with CNTW=16.
- Reset mid-operation: rst_n low with 3 beats buffered in ch1 → m00[1].valid=0 and fifo_full=0 immediately (asynchronous); after release, ch1 delivers only beats written after reset.
